// File: rtl/dma_read_addr_issuer.sv
// Splits each line-segment command into an even then an odd AXI4 AR burst with outstanding-burst credit tracking.
// Optional define DMA_AR_4K_CHECK_EN flags bursts that cross a 4 KB boundary.
module dma_read_addr_issuer #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] even_addr_i,
    input  logic [ADDR_W-1:0] odd_addr_i,
    input  logic [7:0]        len_i,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    output logic              m_arid_o,
    input  logic              burst_done_i,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              idle_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

    localparam logic [2:0]       AR_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_OUTSTANDING - 2);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] odd_addr_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic              ar_id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic accept;
    logic load_even;
    logic load_odd;
    logic ar_hs;
    logic underflow;
    logic xing;

    // Accept only with room for both bursts of the command.
    assign ready_o = rst_n_i && (state_q == IDLE) && (cnt_q <= CNT_LIM);
    assign accept  = valid_i && ready_o;
    assign ar_hs   = m_arvalid_o && m_arready_i;

    always_comb begin
        state_d   = state_q;
        load_even = 1'b0;
        load_odd  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load_even = 1'b1;
                    state_d   = EVEN;
                end
            end
            EVEN: begin
                if (m_arready_i) begin
                    load_odd = 1'b1;
                    state_d  = ODD;
                end
            end
            ODD: begin
                if (m_arready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            odd_addr_q <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= 1'b0;
        end else if (load_even) begin
            odd_addr_q <= odd_addr_i;
            ar_addr_q  <= even_addr_i;
            ar_len_q   <= len_i;
            ar_id_q    <= 1'b0;
        end else if (load_odd) begin
            ar_addr_q <= odd_addr_q;
            ar_id_q   <= 1'b1;
        end
    end

`ifdef DMA_AR_4K_CHECK_EN
    localparam int BEAT_B = DATA_W / 8;

    logic [17:0] burst_b;
    logic [17:0] even_end;
    logic [17:0] odd_end;

    assign burst_b  = (18'(len_i) + 18'd1) * 18'(BEAT_B);
    assign even_end = 18'(even_addr_i[11:0]) + burst_b;
    assign odd_end  = 18'(odd_addr_i[11:0]) + burst_b;
    assign xing     = accept && ((even_end > 18'd4096) || (odd_end > 18'd4096));
`else
    assign xing = 1'b0;
`endif

    // A completion with nothing outstanding is a protocol fault, not a credit.
    assign underflow = burst_done_i && !ar_hs && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (ar_hs && !burst_done_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!ar_hs && burst_done_i && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (underflow || xing) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_arvalid_o   = (state_q == EVEN) || (state_q == ODD);
    assign m_araddr_o    = ar_addr_q;
    assign m_arlen_o     = ar_len_q;
    assign m_arsize_o    = AR_SIZE;
    assign m_arburst_o   = 2'b01;
    assign m_arid_o      = ar_id_q;
    assign outstanding_o = cnt_q;
    assign idle_o        = (state_q == IDLE) && (cnt_q == '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_dma_read_addr_issuer.sv
// Directed bench for dma_read_addr_issuer (ADDR_W=32, DATA_W=64, MAX_OUTSTANDING=8).
module tb_dma_read_addr_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [31:0] even_addr;
    logic [31:0] odd_addr;
    logic [7:0]  len;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arid;
    logic        done;
    logic [3:0]  outstanding;
    logic        idle;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dma_read_addr_issuer #(
        .ADDR_W(32),
        .DATA_W(64),
        .MAX_OUTSTANDING(8)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .valid_i(valid),
        .ready_o(ready),
        .even_addr_i(even_addr),
        .odd_addr_i(odd_addr),
        .len_i(len),
        .m_arvalid_o(arvalid),
        .m_arready_i(arready),
        .m_araddr_o(araddr),
        .m_arlen_o(arlen),
        .m_arsize_o(arsize),
        .m_arburst_o(arburst),
        .m_arid_o(arid),
        .burst_done_i(done),
        .outstanding_o(outstanding),
        .idle_o(idle),
        .err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        even_addr = '0;
        odd_addr = '0;
        len = '0;
        arready = 1'b0;
        done = 1'b0;
        #3;
        check("rst_ready", ready, 0);
        check("rst_idle", idle, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_cnt", outstanding, 0);
        check("rst_err", err, 0);
        check("rst_araddr", araddr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single command, arready held high
        arready = 1'b1;
        valid = 1'b1;
        even_addr = 32'h1000;
        odd_addr = 32'h1400;
        len = 8'd15;
        check("s_ready", ready, 1);
        tick();
        valid = 1'b0;
        check("s_ev_valid", arvalid, 1);
        check("s_ev_addr", araddr, 32'h1000);
        check("s_ev_id", arid, 0);
        check("s_ev_len", arlen, 15);
        check("s_ev_cnt", outstanding, 0);
        tick();
        check("s_od_valid", arvalid, 1);
        check("s_od_addr", araddr, 32'h1400);
        check("s_od_id", arid, 1);
        check("s_od_len", arlen, 15);
        check("s_od_cnt", outstanding, 1);
        tick();
        check("s_end_valid", arvalid, 0);
        check("s_size", arsize, 3);
        check("s_burst", arburst, 2'b01);
        check("s_cnt2", outstanding, 2);
        check("s_idle0", idle, 0);
        check("s_ready2", ready, 1);
        pulse_done();
        check("s_cnt1", outstanding, 1);
        pulse_done();
        check("s_cnt0", outstanding, 0);
        check("s_idle1", idle, 1);
        check("s_err", err, 0);

        // backpressure on the even beat
        arready = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", arvalid, 1);
            check("bp_addr", araddr, 32'h1000);
            check("bp_id", arid, 0);
            tick();
        end
        arready = 1'b1;
        check("bp_hold", araddr, 32'h1000);
        tick();
        check("bp_odd_addr", araddr, 32'h1400);
        check("bp_odd_id", arid, 1);
        tick();
        check("bp_done_valid", arvalid, 0);
        check("bp_cnt", outstanding, 2);
        pulse_done();
        pulse_done();
        check("bp_drain", outstanding, 0);

        // credit limit: four commands back to back
        for (int c = 0; c < 4; c++) begin
            check("cl_ready", ready, 1);
            valid = 1'b1;
            even_addr = 32'h3000 + 32'(c) * 32'h100;
            odd_addr = 32'h5000 + 32'(c) * 32'h100;
            tick();
            valid = 1'b0;
            tick();
            tick();
        end
        check("cl_cnt8", outstanding, 8);
        check("cl_ready0", ready, 0);
        pulse_done();
        check("cl_cnt7", outstanding, 7);
        check("cl_ready7", ready, 0);
        pulse_done();
        check("cl_cnt6", outstanding, 6);
        check("cl_ready6", ready, 1);

        // AR handshake coinciding with a completion
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("sim_pre", outstanding, 6);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sim_same", outstanding, 6);
        tick();
        check("sim_after", outstanding, 7);
        for (int i = 0; i < 7; i++) begin
            pulse_done();
        end
        check("sim_drain", outstanding, 0);
        check("sim_err", err, 0);

        // completion with nothing outstanding
        pulse_done();
        check("uf_err", err, 1);
        check("uf_cnt", outstanding, 0);
        tick();
        tick();
        check("uf_sticky", err, 1);

        // reset while the odd beat is stalled
        valid = 1'b1;
        even_addr = 32'h7000;
        odd_addr = 32'h7400;
        tick();
        valid = 1'b0;
        tick();
        arready = 1'b0;
        tick();
        check("mr_odd_valid", arvalid, 1);
        check("mr_odd_id", arid, 1);
        rst_n = 1'b0;
        #1;
        check("mr_arvalid", arvalid, 0);
        check("mr_cnt", outstanding, 0);
        check("mr_ready", ready, 0);
        check("mr_idle", idle, 1);
        check("mr_err", err, 0);
        check("mr_addr", araddr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_post_idle", idle, 1);
        arready = 1'b1;
        valid = 1'b1;
        even_addr = 32'h2000;
        odd_addr = 32'h2400;
        len = 8'd7;
        tick();
        valid = 1'b0;
        check("nc_ev_addr", araddr, 32'h2000);
        check("nc_ev_id", arid, 0);
        check("nc_ev_len", arlen, 7);
        tick();
        check("nc_od_addr", araddr, 32'h2400);
        check("nc_od_id", arid, 1);
        tick();
        check("nc_valid", arvalid, 0);
        check("nc_cnt", outstanding, 2);
        check("nc_err", err, 0);
        pulse_done();
        pulse_done();

`ifdef DMA_AR_4K_CHECK_EN
        valid = 1'b1;
        even_addr = 32'h0F80;
        odd_addr = 32'h2000;
        len = 8'd31;
        tick();
        valid = 1'b0;
        check("x4k_err", err, 1);
        check("x4k_addr", araddr, 32'h0F80);
        check("x4k_len", arlen, 31);
        tick();
        tick();
        check("x4k_cnt", outstanding, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_read_addr_issuer.md
# dma_read_addr_issuer

Downstream stage of the DMA read address former. Accepts one command per line segment (even-column address, odd-column address, burst length) over a valid/ready handshake. Serialises each command into two AXI4 read-address (AR) beats: even first, then odd. Tracks outstanding bursts so the read-data path is never over-subscribed.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, AXI data width in bits; power of two, 8..1024
- MAX_OUTSTANDING, 8, maximum issued-but-not-completed bursts; even, >= 2

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  command valid from address former
- ready_o  out  1  command accept
- even_addr_i  in  ADDR_W  even-column burst byte address
- odd_addr_i  in  ADDR_W  odd-column burst byte address
- len_i  in  8  AXI burst length (beats - 1), applied to both bursts
- m_arvalid_o  out  1  AR valid
- m_arready_i  in  1  AR ready
- m_araddr_o  out  ADDR_W  AR address
- m_arlen_o  out  8  AR length
- m_arsize_o  out  3  constant log2(DATA_W/8)
- m_arburst_o  out  2  constant 2'b01 (INCR)
- m_arid_o  out  1  0 = even burst, 1 = odd burst
- burst_done_i  in  1  one pulse per completed burst (RVALID & RREADY & RLAST)
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
- idle_o  out  1  IDLE state and outstanding_o == 0
- err_o  out  1  sticky error flag

## Operation
- FSM states: IDLE, EVEN, ODD.
- IDLE:
  - ready_o = 1 when outstanding_o <= MAX_OUTSTANDING-2, i.e. room for both bursts.
  - On valid_i & ready_o: capture odd_addr_i and len_i; load the AR registers with even_addr_i, len_i, id 0; go to EVEN.
- EVEN:
  - m_arvalid_o = 1 with the even beat.
  - On m_arready_i: load the AR registers with the captured odd address, id 1; go to ODD.
- ODD:
  - m_arvalid_o = 1 with the odd beat.
  - On m_arready_i: go to IDLE.
- AR payload is stable while m_arvalid_o is high and m_arready_i is low. m_arvalid_o never drops without a handshake.
- Outstanding counter:
  - +1 on each AR handshake; -1 on burst_done_i.
  - Both in the same cycle: count unchanged.
  - burst_done_i at count 0: count stays 0 and err_o is set.
  - Count never exceeds MAX_OUTSTANDING, by construction of the ready_o rule.
- err_o clears only on reset.
- Reset (asynchronous, any state, mid-burst included):
  - state IDLE; outstanding_o 0; m_arvalid_o 0; m_araddr_o 0; m_arlen_o 0; m_arid_o 0; err_o 0.
  - ready_o 0 while rst_n_i is low; idle_o 1.
  - A half-issued command is discarded.
  - m_arsize_o and m_arburst_o are constants.

## Timing
- Command accepted at edge N: even AR valid from cycle N+1.
- Even handshake at edge M: odd AR valid from cycle M+1.
- Odd handshake at edge K: ready_o may be high in cycle K+1.
- Minimum 3 cycles per command with m_arready_i held high.
- ready_o is combinational from state and count; it does not depend on valid_i.
- burst_done_i takes effect on the count at the next edge, so ready_o may rise one cycle after the completing pulse.

## Configuration
- DMA_AR_4K_CHECK_EN defined:
  - At command accept, each address is checked independently.
  - Check: addr[11:0] + (len_i+1)*(DATA_W/8) > 4096 means the burst crosses a 4 KB boundary.
  - Either crossing sets err_o. The command is still issued unchanged.
- DMA_AR_4K_CHECK_EN not defined: no boundary logic; err_o reflects only counter underflow.

## Test plan
- Single command (DATA_W=64): even 0x1000, odd 0x1400, len 15, m_arready_i held 1.
  - AR beats (0x1000, id 0, len 15) then (0x1400, id 1, len 15) in consecutive cycles.
  - m_arsize_o = 3, m_arburst_o = 2'b01, outstanding_o = 2.
  - After two burst_done_i pulses: outstanding_o = 0, idle_o = 1.
- Backpressure: m_arready_i low for 5 cycles during EVEN.
  - m_araddr_o holds 0x1000 and m_arvalid_o stays 1 throughout; odd beat follows the handshake.
- Credit limit (MAX_OUTSTANDING=8): 4 back-to-back commands, no burst_done_i.
  - outstanding_o = 8 and ready_o = 0.
  - One burst_done_i: count drops to 7, ready_o stays 0.
  - Second burst_done_i: count 6, ready_o = 1.
- Simultaneous AR handshake and burst_done_i: outstanding_o unchanged that edge.
- burst_done_i while outstanding_o = 0: err_o = 1 and stays 1; count stays 0.
  - With DMA_AR_4K_CHECK_EN: even 0x0F80, len 31, DATA_W=64 (256 B) sets err_o.
- Reset asserted while in ODD with m_arready_i low:
  - m_arvalid_o = 0, outstanding_o = 0, state IDLE.
  - After release a new command (0x2000, 0x2400, len 7) issues normally.
